// File: rtl/dmux8_rr_arbiter.sv
// Round-robin arbiter for 8 requesters with a bounded hold time per grant.
// The registered winner index and valid bit drive a DMux8Way that forms the one-hot grant bus.

module DMux8Way (
  input  logic       in,
  input  logic [2:0] sel,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       h
);
  assign a = in & (sel == 3'd0);
  assign b = in & (sel == 3'd1);
  assign c = in & (sel == 3'd2);
  assign d = in & (sel == 3'd3);
  assign e = in & (sel == 3'd4);
  assign f = in & (sel == 3'd5);
  assign g = in & (sel == 3'd6);
  assign h = in & (sel == 3'd7);
endmodule

module dmux8_rr_arbiter #(
  parameter int unsigned HOLD   = 4,
  parameter int unsigned HOLD_W = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [7:0]        req,
  output logic [2:0]        sel,
  output logic              valid,
  output logic [7:0]        grant,
  output logic [HOLD_W-1:0] hold_cnt
);
  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  state_t            r_state, w_state_nx;
  logic [2:0]        r_sel, w_sel_nx;
  logic              r_valid, w_valid_nx;
  logic [HOLD_W-1:0] r_hold, w_hold_nx;
  logic [2:0]        r_ptr, w_ptr_nx;
  logic [2:0]        w_winner;
  logic              w_found;
  logic              w_release;

  // First requester in rotating order starting at r_ptr.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!w_found && req[3'(r_ptr + 3'(i))]) begin
        w_winner = 3'(r_ptr + 3'(i));
        w_found  = 1'b1;
      end
    end
  end

  assign w_release = !req[r_sel] || (r_hold == HOLD_LAST);

  always_comb begin
    w_state_nx = r_state;
    w_sel_nx   = r_sel;
    w_valid_nx = r_valid;
    w_hold_nx  = r_hold;
    w_ptr_nx   = r_ptr;
    unique case (r_state)
      IDLE: begin
        w_valid_nx = 1'b0;
        w_hold_nx  = '0;
        if (w_found) begin
          w_sel_nx   = w_winner;
          w_valid_nx = 1'b1;
          w_ptr_nx   = w_winner + 3'd1;
          w_state_nx = GRANT;
        end
      end
      GRANT: begin
        if (!w_release) begin
          w_hold_nx = r_hold + HOLD_ONE;
        end else if (w_found) begin
          // Re-arbitrate in the release cycle; ptr already ranks the holder last.
          w_sel_nx  = w_winner;
          w_hold_nx = '0;
          w_ptr_nx  = w_winner + 3'd1;
        end else begin
          w_valid_nx = 1'b0;
          w_hold_nx  = '0;
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_hold  <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_sel   <= w_sel_nx;
      r_valid <= w_valid_nx;
      r_hold  <= w_hold_nx;
      r_ptr   <= w_ptr_nx;
    end
  end

  DMux8Way u_dmux (
    .in  (r_valid),
    .sel (r_sel),
    .a   (grant[0]),
    .b   (grant[1]),
    .c   (grant[2]),
    .d   (grant[3]),
    .e   (grant[4]),
    .f   (grant[5]),
    .g   (grant[6]),
    .h   (grant[7])
  );

  assign sel      = r_sel;
  assign valid    = r_valid;
  assign hold_cnt = r_hold;
endmodule

// File: tb/tb_dmux8_rr_arbiter.sv
// Directed and randomized checks of dmux8_rr_arbiter against a behavioural round-robin model.

module tb_dmux8_rr_arbiter;
  localparam int HOLD   = 4;
  localparam int HOLD_W = 3;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [7:0]        req;
  logic [2:0]        sel;
  logic              valid;
  logic [7:0]        grant;
  logic [HOLD_W-1:0] hold_cnt;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: holder index, whether someone holds, cycles spent, priority start.
  int m_sel   = 0;
  bit m_valid = 0;
  int m_cnt   = 0;
  int m_ptr   = 0;

  dmux8_rr_arbiter #(.HOLD(HOLD), .HOLD_W(HOLD_W)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req      (req),
    .sel      (sel),
    .valid    (valid),
    .grant    (grant),
    .hold_cnt (hold_cnt)
  );

  always #5 clock = ~clock;

  function automatic int pick(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++) begin
      if (r[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_update();
    int w;
    if (!reset_n) begin
      m_sel = 0; m_valid = 0; m_cnt = 0; m_ptr = 0;
    end else if (m_valid && req[m_sel] && m_cnt < HOLD - 1) begin
      m_cnt = m_cnt + 1;
    end else begin
      w = pick(req, m_ptr);
      if (w >= 0) begin
        m_sel = w; m_valid = 1; m_cnt = 0; m_ptr = (w + 1) % 8;
      end else begin
        m_valid = 0; m_cnt = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [7:0] eg;
    eg = m_valid ? 8'(1 << m_sel) : 8'h00;
    chk("grant", grant, eg);
    chk("valid", {7'd0, valid}, {7'd0, m_valid});
    chk("sel", {5'd0, sel}, 8'(m_sel));
    chk("hold_cnt", {5'd0, hold_cnt}, 8'(m_cnt));
  endtask

  task automatic step();
    @(posedge clock);
    model_update();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    req     = 8'hFF;

    // Reset with all requests asserted
    step();
    step();
    chk("rst_grant", grant, 8'h00);
    chk("rst_valid", {7'd0, valid}, 8'h00);
    chk("rst_sel", {5'd0, sel}, 8'h00);
    chk("rst_hold", {5'd0, hold_cnt}, 8'h00);

    // Single requester holds, then is re-granted with no gap
    reset_n = 1'b1;
    req = 8'h08;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("solo_grant", grant, 8'h08);
      chk("solo_hold", {5'd0, hold_cnt}, 8'(i));
    end
    step();
    chk("solo_regrant", grant, 8'h08);
    chk("solo_regrant_hold", {5'd0, hold_cnt}, 8'h00);

    // All requesting: four cycles each in rotation, wrapping back to 0
    do_reset();
    req = 8'hFF;
    for (int n = 0; n < 33; n++) begin
      step();
      chk("rotate", grant, 8'(1 << ((n / 4) % 8)));
    end

    // Holder drops its request: grant stays for the sampling cycle, then moves on
    do_reset();
    req = 8'h03;
    step();
    chk("drop_g0", grant, 8'h01);
    step();
    chk("drop_g1", grant, 8'h01);
    req = 8'h02;
    #1;
    chk("drop_sampling", grant, 8'h01);
    step();
    chk("drop_next", grant, 8'h02);
    chk("drop_next_hold", {5'd0, hold_cnt}, 8'h00);

    // Reset during an active grant
    do_reset();
    req = 8'h20;
    step();
    chk("pre_rst_grant", grant, 8'h20);
    reset_n = 1'b0;
    step();
    chk("mid_rst_grant", grant, 8'h00);
    reset_n = 1'b1;
    req = 8'h21;
    step();
    chk("post_rst_grant", grant, 8'h01);

    // Release to idle keeps the last sel
    do_reset();
    req = 8'h20;
    step();
    req = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_grant", grant, 8'h00);
      chk("idle_sel", {5'd0, sel}, 8'h05);
    end

    // Randomized traffic with occasional resets
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0: req = 8'h00;
          1: req = 8'(1 << $urandom_range(0, 7));
          default: req = 8'($urandom);
        endcase
      end
      reset_n = ($urandom_range(0, 63) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
